// File: rtl/hash_rob_pkg.sv
// Shared entry type and width helpers for the hash-row reorder buffer.
// Entry fields are sized for the widest supported address and match length.
package hash_rob_pkg;

    localparam int ROB_ADDR_MAX = 32;
    localparam int ROB_MML_MAX  = 5;

    typedef struct packed {
        logic                    history_valid;
        logic [ROB_ADDR_MAX-1:0] history_addr;
        logic [ROB_MML_MAX-1:0]  mml;
        logic                    can_ext;
        logic [7:0]              data;
    } rob_entry_t;

    function automatic int issue_log2(input int issue_width);
        return $clog2(issue_width);
    endfunction

    function automatic int depth_log2(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int window_idx_width(input int addr_width, input int issue_width);
        return addr_width - $clog2(issue_width);
    endfunction

endpackage

// File: rtl/hash_rob_window_slot.sv
// One in-flight window: entry storage, fill bitmap and delimiter tracking.
// A write in the same cycle as a clear survives, so a slot can be refilled at once.
module hash_rob_window_slot
    import hash_rob_pkg::*;
#(
    parameter int NUM_LANES   = 16,
    parameter int ISSUE_WIDTH = 16,
    localparam int ISSUE_LOG2 = issue_log2(ISSUE_WIDTH)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clear,
    input  logic [NUM_LANES-1:0]                 wr_en,
    input  logic [NUM_LANES-1:0][ISSUE_LOG2-1:0] wr_pos,
    input  logic [NUM_LANES-1:0]                 wr_delim,
    input  rob_entry_t                           wr_entry [NUM_LANES],
    output rob_entry_t                           entries [ISSUE_WIDTH],
    output logic [ISSUE_WIDTH-1:0]               row_valid,
    output logic                                 delim_seen,
    output logic                                 complete,
    output logic                                 occupied,
    output logic                                 dup_write
);

    rob_entry_t             entries_q [ISSUE_WIDTH];
    rob_entry_t             entries_d [ISSUE_WIDTH];
    logic [ISSUE_WIDTH-1:0] fill_q, fill_d;
    logic                   delim_seen_q, delim_seen_d;
    logic [ISSUE_LOG2-1:0]  delim_pos_q, delim_pos_d;
    logic [ISSUE_WIDTH-1:0] upto_delim;

    always_comb begin
        fill_d       = clear ? '0 : fill_q;
        delim_seen_d = clear ? 1'b0 : delim_seen_q;
        delim_pos_d  = delim_pos_q;
        entries_d    = entries_q;
        dup_write    = 1'b0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (wr_en[l]) begin
                dup_write              = dup_write | fill_q[wr_pos[l]];
                fill_d[wr_pos[l]]      = 1'b1;
                entries_d[wr_pos[l]]   = wr_entry[l];
                if (wr_delim[l]) begin
                    delim_seen_d = 1'b1;
                    delim_pos_d  = wr_pos[l];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q       <= '0;
            delim_seen_q <= 1'b0;
            delim_pos_q  <= '0;
        end else begin
            fill_q       <= fill_d;
            delim_seen_q <= delim_seen_d;
            delim_pos_q  <= delim_pos_d;
        end
    end

    // Payload needs no reset: only positions with a fill bit are ever emitted.
    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

    always_comb begin
        upto_delim = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            upto_delim[i] = ~delim_seen_q | (ISSUE_LOG2'(i) <= delim_pos_q);
        end
    end

    assign entries    = entries_q;
    assign row_valid  = fill_q & upto_delim;
    assign delim_seen = delim_seen_q;
    assign complete   = &(fill_q | ~upto_delim);
    assign occupied   = (|fill_q) | delim_seen_q;

endmodule

// File: rtl/hash_row_reorder_buffer.sv
// Reassembles out-of-order hash-row results into address-ordered windows,
// emitted whole or cut short by a stream delimiter, under a window credit limit.
module hash_row_reorder_buffer
    import hash_rob_pkg::*;
#(
    parameter int NUM_LANES   = 16,
    parameter int ISSUE_WIDTH = 16,
    parameter int DEPTH       = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int MML_WIDTH   = 5,
    localparam int ISSUE_LOG2 = issue_log2(ISSUE_WIDTH),
    localparam int DEPTH_LOG2 = depth_log2(DEPTH)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DEPTH_LOG2:0]               cfg_max_queued_windows,
    input  logic                              input_valid,
    input  logic [NUM_LANES-1:0]              input_mask,
    input  logic [NUM_LANES*ADDR_WIDTH-1:0]   input_addr_vec,
    input  logic [NUM_LANES-1:0]              input_history_valid_vec,
    input  logic [NUM_LANES*ADDR_WIDTH-1:0]   input_history_addr_vec,
    input  logic [NUM_LANES*MML_WIDTH-1:0]    input_meta_match_len_vec,
    input  logic [NUM_LANES-1:0]              input_meta_match_can_ext_vec,
    input  logic [NUM_LANES-1:0]              input_delim_vec,
    input  logic [NUM_LANES*8-1:0]            input_data_vec,
    output logic                              input_ready,
    output logic                              output_valid,
    output logic [ADDR_WIDTH-1:0]             output_head_addr,
    output logic [ISSUE_WIDTH-1:0]            output_row_valid,
    output logic [ISSUE_WIDTH-1:0]            output_history_valid,
    output logic [ISSUE_WIDTH*ADDR_WIDTH-1:0] output_history_addr,
    output logic [ISSUE_WIDTH*MML_WIDTH-1:0]  output_meta_match_len,
    output logic [ISSUE_WIDTH-1:0]            output_meta_match_can_ext,
    output logic [ISSUE_WIDTH*8-1:0]          output_data,
    output logic                              output_delim,
    input  logic                              output_ready,
    output logic [DEPTH_LOG2:0]               occupancy,
    output logic                              err_dup_write
);

    localparam int WIN_W = window_idx_width(ADDR_WIDTH, ISSUE_WIDTH);
    localparam logic [DEPTH_LOG2:0] CREDIT_MAX = (DEPTH_LOG2+1)'(DEPTH);

    logic [WIN_W-1:0]                      head_win_q, head_win_d;
    logic [DEPTH_LOG2-1:0]                 head_slot;
    logic [DEPTH_LOG2:0]                   eff_max;
    logic [NUM_LANES-1:0][ADDR_WIDTH-1:0]  lane_addr;
    logic [NUM_LANES-1:0][WIN_W-1:0]       lane_win, lane_dist;
    logic [NUM_LANES-1:0][ISSUE_LOG2-1:0]  lane_pos;
    logic [NUM_LANES-1:0][DEPTH_LOG2-1:0]  lane_slot;
    logic [NUM_LANES-1:0]                  lane_ok;
    rob_entry_t                            lane_entry [NUM_LANES];
    logic                                  accept, load;

    rob_entry_t                            slot_entries [DEPTH][ISSUE_WIDTH];
    logic [DEPTH-1:0][ISSUE_WIDTH-1:0]     slot_row_valid;
    logic [DEPTH-1:0]                      slot_delim, slot_complete, slot_occupied, slot_dup;

    logic                                  out_valid_q, out_valid_d;
    logic [ADDR_WIDTH-1:0]                 out_head_addr_q, out_head_addr_d;
    logic [ISSUE_WIDTH-1:0]                out_row_valid_q, out_row_valid_d;
    logic                                  out_delim_q, out_delim_d;
    rob_entry_t                            out_entries_q [ISSUE_WIDTH];
    rob_entry_t                            out_entries_d [ISSUE_WIDTH];
    logic                                  err_dup_q, err_dup_d;

    always_comb begin
        if (cfg_max_queued_windows == '0) begin
            eff_max = (DEPTH_LOG2+1)'(1);
        end else if (cfg_max_queued_windows > CREDIT_MAX) begin
            eff_max = CREDIT_MAX;
        end else begin
            eff_max = cfg_max_queued_windows;
        end
    end

    // Distance is taken modulo the window-index space so the index may wrap.
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            lane_addr[l]                = input_addr_vec[l*ADDR_WIDTH +: ADDR_WIDTH];
            lane_win[l]                 = lane_addr[l][ADDR_WIDTH-1:ISSUE_LOG2];
            lane_pos[l]                 = lane_addr[l][ISSUE_LOG2-1:0];
            lane_slot[l]                = lane_win[l][DEPTH_LOG2-1:0];
            lane_dist[l]                = lane_win[l] - head_win_q;
            lane_ok[l]                  = ~input_mask[l] | (lane_dist[l] < WIN_W'(eff_max));
            lane_entry[l].history_valid = input_history_valid_vec[l];
            lane_entry[l].history_addr  = ROB_ADDR_MAX'(input_history_addr_vec[l*ADDR_WIDTH +: ADDR_WIDTH]);
            lane_entry[l].mml           = ROB_MML_MAX'(input_meta_match_len_vec[l*MML_WIDTH +: MML_WIDTH]);
            lane_entry[l].can_ext       = input_meta_match_can_ext_vec[l];
            lane_entry[l].data          = input_data_vec[l*8 +: 8];
        end
    end

    assign input_ready = ~rst & (&lane_ok);
    assign accept      = input_valid & input_ready;
    assign head_slot   = head_win_q[DEPTH_LOG2-1:0];
    assign load        = slot_complete[head_slot] & (~out_valid_q | output_ready);

    for (genvar s = 0; s < DEPTH; s++) begin : g_slot
        logic [NUM_LANES-1:0] wr_en;

        always_comb begin
            for (int l = 0; l < NUM_LANES; l++) begin
                wr_en[l] = accept & input_mask[l] & (lane_slot[l] == DEPTH_LOG2'(s));
            end
        end

        hash_rob_window_slot #(
            .NUM_LANES   (NUM_LANES),
            .ISSUE_WIDTH (ISSUE_WIDTH)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .clear      (load && (head_slot == DEPTH_LOG2'(s))),
            .wr_en      (wr_en),
            .wr_pos     (lane_pos),
            .wr_delim   (input_delim_vec),
            .wr_entry   (lane_entry),
            .entries    (slot_entries[s]),
            .row_valid  (slot_row_valid[s]),
            .delim_seen (slot_delim[s]),
            .complete   (slot_complete[s]),
            .occupied   (slot_occupied[s]),
            .dup_write  (slot_dup[s])
        );
    end

    // Positions outside row_valid are zeroed so the held output is fully defined.
    always_comb begin
        out_valid_d     = out_valid_q;
        out_head_addr_d = out_head_addr_q;
        out_row_valid_d = out_row_valid_q;
        out_delim_d     = out_delim_q;
        out_entries_d   = out_entries_q;
        head_win_d      = head_win_q;
        err_dup_d       = err_dup_q | (|slot_dup);
        if (load) begin
            out_valid_d     = 1'b1;
            out_head_addr_d = {head_win_q, {ISSUE_LOG2{1'b0}}};
            out_row_valid_d = slot_row_valid[head_slot];
            out_delim_d     = slot_delim[head_slot];
            for (int p = 0; p < ISSUE_WIDTH; p++) begin
                out_entries_d[p] = slot_row_valid[head_slot][p] ? slot_entries[head_slot][p] : '0;
            end
            head_win_d = head_win_q + 1'b1;
        end else if (output_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_win_q      <= '0;
            out_valid_q     <= 1'b0;
            out_head_addr_q <= '0;
            out_row_valid_q <= '0;
            out_delim_q     <= 1'b0;
            err_dup_q       <= 1'b0;
            for (int p = 0; p < ISSUE_WIDTH; p++) begin
                out_entries_q[p] <= '0;
            end
        end else begin
            head_win_q      <= head_win_d;
            out_valid_q     <= out_valid_d;
            out_head_addr_q <= out_head_addr_d;
            out_row_valid_q <= out_row_valid_d;
            out_delim_q     <= out_delim_d;
            err_dup_q       <= err_dup_d;
            out_entries_q   <= out_entries_d;
        end
    end

    // A window held in the output register still counts as pending.
    always_comb begin
        occupancy = (DEPTH_LOG2+1)'(out_valid_q);
        for (int s = 0; s < DEPTH; s++) begin
            occupancy = occupancy + (DEPTH_LOG2+1)'(slot_occupied[s]);
        end
    end

    always_comb begin
        output_history_valid      = '0;
        output_history_addr       = '0;
        output_meta_match_len     = '0;
        output_meta_match_can_ext = '0;
        output_data               = '0;
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
            output_history_valid[p]                         = out_entries_q[p].history_valid;
            output_history_addr[p*ADDR_WIDTH +: ADDR_WIDTH] = out_entries_q[p].history_addr[ADDR_WIDTH-1:0];
            output_meta_match_len[p*MML_WIDTH +: MML_WIDTH] = out_entries_q[p].mml[MML_WIDTH-1:0];
            output_meta_match_can_ext[p]                    = out_entries_q[p].can_ext;
            output_data[p*8 +: 8]                           = out_entries_q[p].data;
        end
    end

    assign output_valid     = out_valid_q;
    assign output_head_addr = out_head_addr_q;
    assign output_row_valid = out_row_valid_q;
    assign output_delim     = out_delim_q;
    assign err_dup_write    = err_dup_q;

endmodule
